// File: rtl/mul_hilo_if.sv
// Handshake and HI/LO bundle between the execute-stage issue logic and mul_hilo_ctrl.
interface mul_hilo_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] wr_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output in_valid, op, src_a, src_b, flush, wr_hi, wr_lo, wr_data, out_ready,
        input  in_ready, out_valid, hi, lo
    );

    modport slave (
        input  in_valid, op, src_a, src_b, flush, wr_hi, wr_lo, wr_data, out_ready,
        output in_ready, out_valid, hi, lo
    );
endinterface

// File: rtl/mul_hilo_ctrl.sv
// Sequential control around a 32x32 signed multiply: operand capture, unsigned
// correction, HI/LO accumulate, direct HI/LO writes, flush and completion handshake.
module mul_hilo_ctrl (
    input  logic         clk,
    input  logic         rst,
    mul_hilo_if.slave    bus
);
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_MADD  = 2'b10;
    localparam logic [1:0] OP_MSUB  = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        ACC  = 3'd2,
        WB   = 3'd3,
        DONE = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic signed [31:0] a_q, a_d;
    logic signed [31:0] b_q, b_d;
    logic [1:0]         op_q, op_d;
    logic [63:0]        prod_q, prod_d;
    logic [63:0]        sum_q, sum_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic               out_valid_q, out_valid_d;

    logic signed [63:0] a_ext, b_ext, p_s;
    logic [63:0]        corr_a, corr_b, hilo;

    // Signed core: both operands sign-extended so the 64-bit product is exact.
    assign a_ext = {{32{a_q[31]}}, a_q};
    assign b_ext = {{32{b_q[31]}}, b_q};
    assign p_s   = a_ext * b_ext;

    // Unsigned reinterpretation adds back 2^32 times the other operand for each negative input.
    assign corr_a = a_q[31] ? {b_q, 32'h0} : 64'h0;
    assign corr_b = b_q[31] ? {a_q, 32'h0} : 64'h0;
    assign hilo   = {hi_q, lo_q};

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        prod_d      = prod_q;
        sum_d       = sum_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            IDLE: begin
                if (bus.wr_hi) hi_d = bus.wr_data;
                if (bus.wr_lo) lo_d = bus.wr_data;
                if (bus.in_valid && !bus.flush) begin
                    a_d     = bus.src_a;
                    b_d     = bus.src_b;
                    op_d    = bus.op;
                    state_d = MUL;
                end
            end
            MUL: begin
                prod_d  = (op_q == OP_MULTU) ? 64'(p_s) + corr_a + corr_b : 64'(p_s);
                state_d = bus.flush ? IDLE : ACC;
            end
            ACC: begin
                case (op_q)
                    OP_MADD: sum_d = hilo + prod_q;
                    OP_MSUB: sum_d = hilo - prod_q;
                    default: sum_d = prod_q;
                endcase
                state_d = bus.flush ? IDLE : WB;
            end
            WB: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else begin
                    {hi_d, lo_d} = sum_q;
                    out_valid_d  = 1'b1;
                    state_d      = DONE;
                end
            end
            DONE: begin
                if (bus.flush || bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= OP_MULT;
            prod_q      <= '0;
            sum_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            prod_q      <= prod_d;
            sum_q       <= sum_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
endmodule
